mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Multi-cycle multiply/divide unit for the execute stage. Implements the full RV64M mdu_op_t set: MUL, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW.
- Parametrised successor to the single-cycle ALU path. Adds width generalisation, a valid/ready handshake, output backpressure and flush.
- Multiply uses a fixed-latency counter. Divide is a restoring, 1-bit-per-cycle iterative datapath.
- Sits beside the ALU. The pipeline stalls execute while a request is in flight.

Parameters:
- XLEN, 64: operand/result width. Legal values 32 and 64. W-ops exist only when XLEN=64.
- MUL_LATENCY, 3: cycles from accept to out_valid for MUL/MULW. Range 1..8.
- WLEN, 32: width used by W-ops.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  abort any in-flight op
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request
- op  in  4  mdu_op_t encoding: NOP=0, MUL=1, DIV=2, DIVU=3, REM=4, REMU=5, MULW=6, DIVW=7, DIVUW=8, REMW=9, REMUW=10
- src_a  in  XLEN  dividend/multiplicand
- src_b  in  XLEN  divisor/multiplier
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  result
- busy  out  1  state != IDLE

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-high. All registered state clears on the reset edge: state=IDLE, out_valid=0, result=0, counters=0. in_ready=1 in the cycle after reset.
- States:
  - IDLE: in_ready=1.
  - MUL: count down MUL_LATENCY-1 cycles.
  - DIV: iterate.
  - FIX: sign correction.
  - DONE: out_valid=1.
- Accept: fires when in_valid && in_ready && !flush, at cycle T. op, src_a and src_b are captured at T. Inputs after T are ignored.
- MUL/MULW:
  - out_valid first asserted at T+MUL_LATENCY.
  - MUL returns the low XLEN bits of src_a*src_b.
  - MULW returns the low 32 bits of the product of src_a[31:0] and src_b[31:0], sign-extended from bit 31.
- DIV family:
  - N = XLEN for 64-bit ops, N = WLEN for W-ops.
  - Signed ops take magnitudes at accept. Iterations run in cycles T+1..T+N. FIX runs at T+N+1, applying the quotient sign (a^b) and the remainder sign (a).
  - out_valid at T+N+2: T+66 for DIV at XLEN=64, T+34 for DIVW.
  - W-ops use the low 32 bits of the operands; the 32-bit result is sign-extended (DIVUW/REMUW included, per ISA).
- Fast paths, out_valid at T+1:
  - divisor==0: quotient = all ones (W: 0xFFFFFFFF sign-extended), remainder = dividend (W: sign-extended low 32).
  - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend, remainder = 0.
  - op==NOP or unknown encoding: result = 0.
- Output:
  - DONE holds out_valid=1 and keeps result stable until out_ready=1.
  - The handshake cycle returns the unit to IDLE on the next edge.
  - No new accept is allowed in the handshake cycle: in_ready stays 0 outside IDLE.
- Flush:
  - In any state, flush forces IDLE on the next edge and clears out_valid.
  - Flush in the same cycle as in_valid in IDLE means no accept.
  - Flush wins over out_ready.
- reset mid-operation: identical to the reset values, with no result emitted.
- busy = (state != IDLE).
- Combinational signals: in_ready depends only on state, never on in_valid. There are no other combinational input-to-output paths except out_valid/result being registered.

Test Plan:
- DIV: reset, then accept DIV src_a=100, src_b=7 at T -> out_valid at T+66, result=14. Repeat with REM src_a=-100, src_b=7 -> result=0xFFFF_FFFF_FFFF_FFFE (-2).
- DIVU by zero: src_a=5, src_b=0 -> out_valid at T+1, result=0xFFFF_FFFF_FFFF_FFFF. REMU with the same operands -> 5.
- Signed overflow: DIV src_a=0x8000_0000_0000_0000, src_b=-1 -> result=0x8000_0000_0000_0000 at T+1. REMW src_a=0x8000_0000, src_b=-1 -> 0.
- MULW: src_a=0x7FFF_FFFF, src_b=2 -> result=0xFFFF_FFFF_FFFF_FFFE at T+3. MUL src_a=-3, src_b=5 -> 0xFFFF_FFFF_FFFF_FFF1.
- Backpressure: DIVW 35/6 with out_ready=0 for 10 cycles after out_valid -> result=5 stays stable and in_ready=0. out_ready=1 -> in_ready=1 on the next cycle.
- Flush at T+20 of a DIV -> out_valid never rises and in_ready=1 at T+21. An immediate new MUL 6*7 -> 42 at its own T'+3. Asserting reset mid-DIV behaves the same way.

Source files
------------

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit for the execute stage (RV64M op set).
// Multiply results appear a fixed MUL_LATENCY cycles after accept. Divide is a
// restoring, 1-bit-per-cycle datapath followed by one sign-correction cycle.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   flush             abort any in-flight op (forces IDLE on the next edge)
//   in_valid/in_ready request handshake; in_ready depends only on state
//   op                mdu_op_t: NOP=0 MUL=1 DIV=2 DIVU=3 REM=4 REMU=5
//                     MULW=6 DIVW=7 DIVUW=8 REMW=9 REMUW=10
//   src_a, src_b      dividend/multiplicand, divisor/multiplier
//   out_valid/out_ready result handshake; result is held stable while stalled
//   result            registered result
//   busy              state != IDLE
module mdu_iter #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned WLEN        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [3:0] OpMul   = 4'd1;
  localparam logic [3:0] OpDiv   = 4'd2;
  localparam logic [3:0] OpDivu  = 4'd3;
  localparam logic [3:0] OpRem   = 4'd4;
  localparam logic [3:0] OpRemu  = 4'd5;
  localparam logic [3:0] OpMulw  = 4'd6;
  localparam logic [3:0] OpDivw  = 4'd7;
  localparam logic [3:0] OpDivuw = 4'd8;
  localparam logic [3:0] OpRemw  = 4'd9;
  localparam logic [3:0] OpRemuw = 4'd10;

  localparam int unsigned CntW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] XMin = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [WLEN-1:0] WMin = {1'b1, {(WLEN-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d;       // multiplicand, or dividend/quotient shift register
  logic [XLEN-1:0]   b_q, b_d;       // multiplier, or divisor magnitude
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              is_w_q, is_w_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = v;
    for (int unsigned i = WLEN; i < XLEN; i++) r[i] = v[WLEN-1];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = v;
    for (int unsigned i = WLEN; i < XLEN; i++) r[i] = 1'b0;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mul_calc(input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b,
                                               input logic            w);
    logic [XLEN-1:0] p;
    p = a * b;
    // Low WLEN bits of the full product equal those of the WLEN x WLEN product.
    return w ? sext_w(p) : p;
  endfunction

  // Request decode
  logic            acc;
  logic            op_w, op_mul, op_div, op_sgn, op_rem;
  logic [XLEN-1:0] a_op, b_op, a_mag, b_mag;
  logic            a_neg, b_neg, a_min, b_m1, b_zero;

  assign acc = in_valid && (state_q == StIdle) && !flush;

  always_comb begin
    op_w   = (XLEN == 64) && (op >= OpMulw) && (op <= OpRemuw);
    op_mul = (op == OpMul) || (op_w && (op == OpMulw));
    op_div = (op >= OpDiv && op <= OpRemu) || (op_w && op >= OpDivw);
    op_sgn = (op == OpDiv) || (op == OpRem) || (op_w && (op == OpDivw || op == OpRemw));
    op_rem = (op == OpRem) || (op == OpRemu) || (op_w && (op == OpRemw || op == OpRemuw));

    a_op = src_a;
    b_op = src_b;
    if (op_w) begin
      a_op = op_sgn ? sext_w(src_a) : zext_w(src_a);
      b_op = op_sgn ? sext_w(src_b) : zext_w(src_b);
    end
    a_neg  = op_sgn && a_op[XLEN-1];
    b_neg  = op_sgn && b_op[XLEN-1];
    a_mag  = a_neg ? -a_op : a_op;
    b_mag  = b_neg ? -b_op : b_op;
    a_min  = op_w ? (src_a[WLEN-1:0] == WMin) : (src_a == XMin);
    b_m1   = op_w ? (&src_b[WLEN-1:0]) : (&src_b);
    b_zero = (b_op == '0);
  end

  // One restoring-division step
  logic [XLEN:0] rem_sh, rem_diff;

  always_comb begin
    rem_sh   = {rem_q, a_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, b_q};
  end

  // Sign correction
  logic [XLEN-1:0] q_raw, q_fix, r_fix, fix_res;

  always_comb begin
    q_raw   = is_w_q ? zext_w(a_q) : a_q;
    q_fix   = neg_q_q ? -q_raw : q_raw;
    r_fix   = neg_r_q ? -rem_q : rem_q;
    fix_res = is_rem_q ? r_fix : q_fix;
    if (is_w_q) fix_res = sext_w(fix_res);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    is_w_d   = is_w_q;
    is_rem_d = is_rem_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;

    unique case (state_q)
      StIdle: begin
        if (acc) begin
          is_w_d   = op_w;
          is_rem_d = op_rem;
          if (op_mul) begin
            a_d = src_a;
            b_d = src_b;
            if (MUL_LATENCY == 1) begin
              result_d = mul_calc(src_a, src_b, op_w);
              state_d  = StDone;
            end else begin
              cnt_d   = CntW'(MUL_LATENCY - 1);
              state_d = StMul;
            end
          end else if (op_div) begin
            if (b_zero) begin
              result_d = op_rem ? (op_w ? sext_w(src_a) : src_a) : '1;
              state_d  = StDone;
            end else if (op_sgn && a_min && b_m1) begin
              result_d = op_rem ? '0 : (op_w ? sext_w(src_a) : src_a);
              state_d  = StDone;
            end else begin
              // W dividends are left-aligned so the MSB-first shift works for both widths.
              a_d     = op_w ? (a_mag << (XLEN - WLEN)) : a_mag;
              b_d     = b_mag;
              rem_d   = '0;
              neg_q_d = a_neg ^ b_neg;
              neg_r_d = a_neg;
              cnt_d   = op_w ? CntW'(WLEN) : CntW'(XLEN);
              state_d = StDiv;
            end
          end else begin
            result_d = '0;
            state_d  = StDone;
          end
        end
      end
      StMul: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          result_d = mul_calc(a_q, b_q, is_w_q);
          state_d  = StDone;
        end
      end
      StDiv: begin
        a_d   = {a_q[XLEN-2:0], ~rem_diff[XLEN]};
        rem_d = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        result_d = fix_res;
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      is_w_q   <= 1'b0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      is_w_q   <= is_w_d;
      is_rem_q <= is_rem_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (XLEN=64, MUL_LATENCY=3).
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]  op;
  logic [63:0] src_a, src_b, result;

  int checks = 0;
  int failures = 0;

  mdu_iter #(.XLEN(64), .MUL_LATENCY(3), .WLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Drive one request; returns in cycle T+1 (#1 after the accept edge).
  task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 4'($urandom_range(0, 10));
    src_a    = {$urandom, $urandom};
    src_b    = {$urandom, $urandom};
  endtask

  // Cycles after accept until out_valid (-1 if it never came).
  task automatic wait_done(output int lat, output logic [63:0] res);
    int k = 1;
    while (!out_valid && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    lat = out_valid ? k : -1;
    res = result;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                        output int lat, output logic [63:0] res);
    issue(o, a, b);
    wait_done(lat, res);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready actual=%b required=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid actual=%b required=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
    checks++; if (result !== 64'd0) begin failures++; $display("FAIL reset_result actual=%h required=0", result); end
  endtask

  task automatic test_div();
    int lat; logic [63:0] res;
    run_op(4'd2, 64'd100, 64'd7, lat, res);
    checks++; if (lat !== 66) begin failures++; $display("FAIL div_latency actual=%0d required=66", lat); end
    checks++; if (res !== 64'd14) begin failures++; $display("FAIL div_result actual=%h required=%h", res, 64'd14); end
    run_op(4'd4, -64'sd100, 64'd7, lat, res);
    checks++; if (lat !== 66) begin failures++; $display("FAIL rem_latency actual=%0d required=66", lat); end
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL rem_result actual=%h required=fffffffffffffffe", res); end
    run_op(4'd2, -64'sd100, 64'd7, lat, res);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFF2) begin failures++; $display("FAIL div_neg_result actual=%h required=fffffffffffffff2", res); end
    run_op(4'd7, 64'hFFFF_FFF9, 64'd2, lat, res);
    checks++; if (lat !== 34) begin failures++; $display("FAIL divw_latency actual=%0d required=34", lat); end
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL divw_neg_result actual=%h required=fffffffffffffffd", res); end
    run_op(4'd10, 64'h1234_5678_FFFF_FFFF, 64'h10, lat, res);
    checks++; if (res !== 64'hF) begin failures++; $display("FAIL remuw_result actual=%h required=f", res); end
    run_op(4'd8, 64'hFFFF_FFFE, 64'd1, lat, res);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL divuw_sext actual=%h required=fffffffffffffffe", res); end
  endtask

  task automatic test_fast_paths();
    int lat; logic [63:0] res;
    run_op(4'd3, 64'd5, 64'd0, lat, res);
    checks++; if (lat !== 1) begin failures++; $display("FAIL divu0_latency actual=%0d required=1", lat); end
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL divu0_result actual=%h required=ffffffffffffffff", res); end
    run_op(4'd5, 64'd5, 64'd0, lat, res);
    checks++; if (lat !== 1) begin failures++; $display("FAIL remu0_latency actual=%0d required=1", lat); end
    checks++; if (res !== 64'd5) begin failures++; $display("FAIL remu0_result actual=%h required=5", res); end
    run_op(4'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, res);
    checks++; if (lat !== 1) begin failures++; $display("FAIL div_ovf_latency actual=%0d required=1", lat); end
    checks++; if (res !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL div_ovf_result actual=%h required=8000000000000000", res); end
    run_op(4'd9, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, res);
    checks++; if (lat !== 1) begin failures++; $display("FAIL remw_ovf_latency actual=%0d required=1", lat); end
    checks++; if (res !== 64'd0) begin failures++; $display("FAIL remw_ovf_result actual=%h required=0", res); end
    run_op(4'd0, 64'd9, 64'd9, lat, res);
    checks++; if (lat !== 1) begin failures++; $display("FAIL nop_latency actual=%0d required=1", lat); end
    checks++; if (res !== 64'd0) begin failures++; $display("FAIL nop_result actual=%h required=0", res); end
  endtask

  task automatic test_mul();
    int lat; logic [63:0] res;
    run_op(4'd6, 64'h7FFF_FFFF, 64'd2, lat, res);
    checks++; if (lat !== 3) begin failures++; $display("FAIL mulw_latency actual=%0d required=3", lat); end
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL mulw_result actual=%h required=fffffffffffffffe", res); end
    run_op(4'd1, -64'sd3, 64'd5, lat, res);
    checks++; if (lat !== 3) begin failures++; $display("FAIL mul_latency actual=%0d required=3", lat); end
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFF1) begin failures++; $display("FAIL mul_result actual=%h required=fffffffffffffff1", res); end
  endtask

  task automatic test_backpressure();
    int lat; logic [63:0] res;
    int bad = 0;
    out_ready = 1'b0;
    issue(4'd7, 64'd35, 64'd6);
    wait_done(lat, res);
    checks++; if (lat !== 34) begin failures++; $display("FAIL bp_latency actual=%0d required=34", lat); end
    checks++; if (res !== 64'd5) begin failures++; $display("FAIL bp_result actual=%h required=5", res); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || result !== 64'd5 || in_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold actual=%0d_bad_cycles required=0", bad); end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready actual=%b required=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid actual=%b required=0", out_valid); end
  endtask

  task automatic test_flush();
    int lat; logic [63:0] res;
    int seen = 0;
    // Flush together with a request in IDLE: no accept.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 4'd1; src_a = 64'd2; src_b = 64'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_idle_accept actual_busy=%b required=0", busy); end
    // Flush mid-DIV at T+20.
    issue(4'd2, 64'd1000, 64'd3);
    repeat (19) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready actual=%b required=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid actual=%b required=0", out_valid); end
    run_op(4'd1, 64'd6, 64'd7, lat, res);
    checks++; if (lat !== 3) begin failures++; $display("FAIL flush_mul_latency actual=%0d required=3", lat); end
    checks++; if (res !== 64'd42) begin failures++; $display("FAIL flush_mul_result actual=%h required=2a", res); end
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL flush_no_late_result actual=%0d required=0", seen); end
  endtask

  task automatic test_reset_mid_div();
    int lat; logic [63:0] res;
    issue(4'd2, 64'd1000, 64'd3);
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready actual=%b required=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid actual=%b required=0", out_valid); end
    checks++; if (result !== 64'd0) begin failures++; $display("FAIL rst_mid_result actual=%h required=0", result); end
    run_op(4'd1, 64'd6, 64'd7, lat, res);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rst_mul_latency actual=%0d required=3", lat); end
    checks++; if (res !== 64'd42) begin failures++; $display("FAIL rst_mul_result actual=%h required=2a", res); end
  endtask

  initial begin
    test_reset();
    test_div();
    test_fast_paths();
    test_mul();
    test_backpressure();
    test_flush();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
